// File: rtl/mat_feeder_if.sv
// Unskewed vector stream into the matrix feeder (valid/ready, last marks end of batch).
interface mat_feeder_if #(
  parameter int unsigned N = 4
) ();
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0][31:0]  in_data;
  logic                in_last;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/mat_feeder.sv
// Systolic-array sequencer: buffers an N x N weight tile, replays it as the diagonal
// weight-load sequence, then skews incoming data vectors (lane i delayed i cycles).
module mat_feeder #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(2*N)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               weight_start,
  mat_feeder_if.slave        s,
  output logic               load_weight,
  output logic [PW-1:0]      weight_progress,
  output logic [N-1:0][31:0] data_out,
  output logic               busy,
  output logic               weights_loaded
);

  localparam int unsigned DW = 32;
  localparam int unsigned JW = $clog2(N);

  typedef enum logic [2:0] {S_IDLE, S_WFILL, S_WLOAD, S_STREAM, S_DRAIN} state_t;

  state_t                state, state_nx;
  logic [JW-1:0]         fill_cnt;
  logic [JW-1:0]         drain_cnt;
  logic [N-1:0][DW-1:0]  wbuf [N];
  logic [N-1:0][DW-1:0]  skew_tail;
  logic                  xfer;
  logic                  push;

  logic                  load_weight_d;
  logic [PW-1:0]         progress_d;
  logic [PW-1:0]         k_nx;
  logic [N-1:0][DW-1:0]  data_out_d;
  logic                  busy_d;
  logic                  weights_loaded_d;

  // weight_start wins over data in IDLE, so ready is withheld while it is high
  assign s.in_ready = (state == S_WFILL) || (state == S_STREAM) ||
                      ((state == S_IDLE) && weights_loaded && !weight_start);
  assign xfer = s.in_valid && s.in_ready;
  assign push = xfer && ((state == S_IDLE) || (state == S_STREAM));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (weight_start)   state_nx = S_WFILL;
        else if (xfer)      state_nx = s.in_last ? S_DRAIN : S_STREAM;
      end
      S_WFILL:  if (xfer && (fill_cnt == JW'(N-1)))            state_nx = S_WLOAD;
      S_WLOAD:  if (weight_progress == PW'(2*N-1))             state_nx = S_STREAM;
      S_STREAM: if (xfer && s.in_last)                         state_nx = S_DRAIN;
      S_DRAIN:  if (drain_cnt == JW'(N-2))                     state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    load_weight_d    = 1'b0;
    progress_d       = '0;
    k_nx             = (state == S_WLOAD) ? weight_progress + PW'(1) : '0;
    data_out_d       = skew_tail;
    busy_d           = (state_nx != S_IDLE);
    weights_loaded_d = weights_loaded || ((state == S_WLOAD) && (state_nx == S_STREAM));
    if (state_nx == S_WLOAD) begin
      load_weight_d = 1'b1;
      progress_d    = k_nx;
      // diagonal k: lane i carries element i of row k-i
      for (int i = 0; i < N; i++) begin
        data_out_d[i] = '0;
        for (int j = 0; j < N; j++)
          if (int'(k_nx) == i + j) data_out_d[i] = wbuf[j][i];
      end
    end
  end

  // Output registers, tile buffer and counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      load_weight     <= 1'b0;
      weight_progress <= '0;
      data_out        <= '0;
      busy            <= 1'b0;
      weights_loaded  <= 1'b0;
      fill_cnt        <= '0;
      drain_cnt       <= '0;
      for (int j = 0; j < N; j++) wbuf[j] <= '0;
    end else begin
      load_weight     <= load_weight_d;
      weight_progress <= progress_d;
      data_out        <= data_out_d;
      busy            <= busy_d;
      weights_loaded  <= weights_loaded_d;
      if (state == S_WFILL) begin
        if (xfer) begin
          wbuf[fill_cnt] <= s.in_data;
          fill_cnt       <= fill_cnt + JW'(1);
        end
      end else begin
        fill_cnt <= '0;
      end
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + JW'(1) : '0;
    end
  end

  // Per-lane delay lines; idle cycles inject zero bubbles
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] dl [i+1];
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int d = 0; d <= i; d++) dl[d] <= '0;
      end else begin
        dl[0] <= push ? s.in_data[i] : '0;
        for (int d = 1; d <= i; d++) dl[d] <= dl[d-1];
      end
    end
    assign skew_tail[i] = dl[i];
  end

endmodule
